seg_led_mux: RTL and testbench

Parametrised multiplexed seven-segment display driver, the successor to the fixed 6-digit hex scanner. It scans DIGITS common-anode/cathode digits with configurable refresh rate and output polarity. It adds per-digit decimal points, per-digit blanking, leading-zero suppression, PWM brightness, a one-cycle anti-ghosting gap, and tear-free frame-synchronous data loading with a load/acknowledge handshake. It sits between any status/debug source and the board's segment pins.

---
 rtl/seg_led_mux.sv | 183 ++++++++++++++++++
 tb/tb_seg_led_mux.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg_led_mux.sv
// rtl/seg_led_mux.sv - parametrised multiplexed seven-segment display driver
module seg_led_mux #(
    parameter int DIGITS         = 6,
    parameter int TICK_DIV       = 50000,
    parameter int PWM_BITS       = 4,
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_en,
    input  logic [PWM_BITS-1:0]   bright,
    output logic                  load_ack,
    output logic                  frame_start,
    output logic [DIGITS-1:0]     seg_sel,
    output logic [7:0]            seg_led
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [TW-1:0]     TIMER_LAST = TW'(TICK_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_OFF    = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        LED_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    // Reject illegal builds at elaboration
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("seg_led_mux: DIGITS must be 1..8");
    end
    if (TICK_DIV < 2) begin : g_bad_tick
        $error("seg_led_mux: TICK_DIV must be >= 2");
    end
    if (PWM_BITS < 1 || PWM_BITS > 8) begin : g_bad_pwm
        $error("seg_led_mux: PWM_BITS must be 1..8");
    end

    logic [TW-1:0]       timer;
    logic [IW-1:0]       idx;
    logic [PWM_BITS-1:0] pwm_cnt;

    logic [4*DIGITS-1:0] pend_data;
    logic [DIGITS-1:0]   pend_dp;
    logic [DIGITS-1:0]   pend_blank;
    logic                pend_lz;
    logic                pend_valid;

    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blank;
    logic                sh_lz;

    logic                boundary;
    logic                pwm_on;
    logic                lit;
    logic                suppress;
    logic [3:0]          nib;
    logic [DIGITS-1:0]   zero_from;
    logic                zero_acc;
    logic [7:0]          pat;
    logic [DIGITS-1:0]   sel_onehot;
    logic [DIGITS-1:0]   sel_next;
    logic [7:0]          led_next;

    // Active-low glyph for one hex nibble, dp segment off
    function automatic logic [7:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            default: glyph = 8'h8E;
        endcase
    endfunction

    // Decode the current slot into next-cycle select and segment values
    always_comb begin
        boundary = (idx == IDX_LAST) && (timer == TIMER_LAST);
        pwm_on   = (bright == {PWM_BITS{1'b1}}) || (pwm_cnt < bright);
        nib      = sh_data[{idx, 2'b00} +: 4];

        // zero_from[k] = nibbles k..DIGITS-1 are all zero
        zero_acc  = 1'b1;
        zero_from = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_acc     = zero_acc & (sh_data[4*k +: 4] == 4'd0);
            zero_from[k] = zero_acc;
        end

        suppress = sh_lz && (idx != '0) && zero_from[idx];
        lit      = (timer != '0) && pwm_on && !sh_blank[idx];

        pat = suppress ? 8'hFF : glyph(nib);
        if (sh_dp[idx]) begin
            pat[7] = 1'b0;
        end

        sel_onehot = DIGITS'(1) << idx;
        sel_next   = lit ? (SEL_ACTIVE_LOW ? ~sel_onehot : sel_onehot) : SEL_OFF;
        led_next   = lit ? (SEG_ACTIVE_LOW ? pat : ~pat) : LED_OFF;
    end

    // Slot timer, digit index and free-running PWM counter
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            timer   <= '0;
            idx     <= '0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (timer == TIMER_LAST) begin
                timer <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    // Pending/shadow register pair; shadow only changes on the frame boundary
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_lz    <= 1'b0;
            pend_valid <= 1'b0;
            sh_data    <= '0;
            sh_dp      <= '0;
            sh_blank   <= '1;
            sh_lz      <= 1'b0;
        end else if (boundary) begin
            pend_valid <= 1'b0;
            if (load) begin
                sh_data  <= data;
                sh_dp    <= dp;
                sh_blank <= blank;
                sh_lz    <= lz_en;
            end else if (pend_valid) begin
                sh_data  <= pend_data;
                sh_dp    <= pend_dp;
                sh_blank <= pend_blank;
                sh_lz    <= pend_lz;
            end
        end else if (load) begin
            pend_data  <= data;
            pend_dp    <= dp;
            pend_blank <= blank;
            pend_lz    <= lz_en;
            pend_valid <= 1'b1;
        end
    end

    // Registered outputs, one cycle behind the scan state
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            seg_sel     <= SEL_OFF;
            seg_led     <= LED_OFF;
            frame_start <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            seg_sel     <= sel_next;
            seg_led     <= led_next;
            frame_start <= boundary;
            load_ack    <= boundary && (load || pend_valid);
        end
    end

endmodule

// File: tb/tb_seg_led_mux.sv
// tb/tb_seg_led_mux.sv - randomized and directed bench for seg_led_mux against a frame-level model
module tb_seg_led_mux;

    localparam int D  = 4;
    localparam int T  = 8;
    localparam int PB = 2;
    localparam int FRAME = D * T;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic        lz_en = 1'b0;
    logic [1:0]  bright = 2'd3;

    logic        load_ack, frame_start;
    logic [3:0]  seg_sel;
    logic [7:0]  seg_led;
    logic        load_ack_h, frame_start_h;
    logic [3:0]  seg_sel_h;
    logic [7:0]  seg_led_h;

    seg_led_mux #(.DIGITS(D), .TICK_DIV(T), .PWM_BITS(PB),
                  .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .load(load), .data(data), .dp(dp),
        .blank(blank), .lz_en(lz_en), .bright(bright), .load_ack(load_ack),
        .frame_start(frame_start), .seg_sel(seg_sel), .seg_led(seg_led)
    );

    seg_led_mux #(.DIGITS(D), .TICK_DIV(T), .PWM_BITS(PB),
                  .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_h (
        .sys_clk(clk), .sys_rst(sys_rst), .load(load), .data(data), .dp(dp),
        .blank(blank), .lz_en(lz_en), .bright(bright), .load_ack(load_ack_h),
        .frame_start(frame_start_h), .seg_sel(seg_sel_h), .seg_led(seg_led_h)
    );

    always #5 clk = ~clk;

    logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Model: cycles since reset plus displayed and pending display sets
    int          n;
    logic [15:0] m_data, p_data;
    logic [3:0]  m_dp, m_blank, p_dp, p_blank;
    logic        m_lz, p_lz, p_v;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at model cycle %0d: observed %h expected %h", tag, n, obs, exp);
        end
    endtask

    task automatic rst_step();
        sys_rst = 1'b1;
        load    = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_sel", {4'h0, seg_sel}, 8'h0F);
        chk("rst_led", seg_led, 8'hFF);
        chk("rst_ack", {7'h0, load_ack}, 8'h00);
        chk("rst_fs", {7'h0, frame_start}, 8'h00);
        chk("rst_sel_h", {4'h0, seg_sel_h}, 8'h00);
        chk("rst_led_h", seg_led_h, 8'h00);
        n = 0; m_data = '0; m_dp = '0; m_blank = 4'hF; m_lz = 1'b0; p_v = 1'b0;
    endtask

    task automatic step();
        int t, d, p;
        logic bnd, lit, supp, led_known;
        logic [7:0] e_sel, e_led, e_fs, e_ack;
        logic [3:0] nib;
        sys_rst = 1'b0;
        t   = n % T;
        d   = (n / T) % D;
        p   = n % (1 << PB);
        bnd = (d == D - 1) && (t == T - 1);
        lit = (t != 0) && ((bright == 2'd3) || (p < int'(bright))) && !m_blank[d];
        nib  = m_data[4*d +: 4];
        supp = m_lz && (d >= 1) && ((m_data >> (4 * d)) == 16'h0);
        e_sel = lit ? (8'h0F & ~(8'h01 << d)) : 8'h0F;
        e_led = supp ? 8'hFF : font[nib];
        if (m_dp[d]) e_led[7] = 1'b0;
        if (!lit) e_led = 8'hFF;
        led_known = lit || (t == 0) || m_blank[d];
        e_fs  = {7'h0, bnd};
        e_ack = {7'h0, bnd && (load || p_v)};
        if (bnd) begin
            if (load) begin
                m_data = data; m_dp = dp; m_blank = blank; m_lz = lz_en;
            end else if (p_v) begin
                m_data = p_data; m_dp = p_dp; m_blank = p_blank; m_lz = p_lz;
            end
            p_v = 1'b0;
        end else if (load) begin
            p_data = data; p_dp = dp; p_blank = blank; p_lz = lz_en; p_v = 1'b1;
        end
        n++;
        @(posedge clk);
        #1;
        chk("sel", {4'h0, seg_sel}, e_sel);
        if (led_known) chk("led", seg_led, e_led);
        chk("frame_start", {7'h0, frame_start}, e_fs);
        chk("load_ack", {7'h0, load_ack}, e_ack);
        chk("sel_h", {4'h0, seg_sel_h}, 8'h0F & ~e_sel);
        if (led_known) chk("led_h", seg_led_h, ~e_led);
        chk("ack_h", {7'h0, load_ack_h}, e_ack);
        chk("fs_h", {7'h0, frame_start_h}, e_fs);
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    task automatic do_load(input logic [15:0] dv, input logic [3:0] dpv,
                           input logic [3:0] bv, input logic lz);
        data = dv; dp = dpv; blank = bv; lz_en = lz; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic align(input int phase);
        while ((n % FRAME) != phase) step();
    endtask

    initial begin
        p_data = '0; p_dp = '0; p_blank = '0; p_lz = 1'b0;
        repeat (3) rst_step();

        // Idle after reset: dark, frame_start at cycle 32 and every 32 after
        bright = 2'd3;
        run(70);

        // Basic hex pattern
        do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
        run(2 * FRAME);

        // Leading-zero suppression with dp on a suppressed digit
        do_load(16'h0030, 4'b0100, 4'h0, 1'b1);
        run(2 * FRAME);

        // Two loads in one frame: last wins, single ack
        align(2);
        do_load(16'h1111, 4'h0, 4'h0, 1'b0);
        run(5);
        do_load(16'h2222, 4'h0, 4'h0, 1'b0);
        run(2 * FRAME);

        // Load landing exactly on the boundary cycle
        align(FRAME - 1);
        do_load(16'h9E4C, 4'b1001, 4'h0, 1'b0);
        run(FRAME + 2);

        // Brightness extremes and a middle value
        bright = 2'd1; run(FRAME);
        bright = 2'd0; run(FRAME);
        bright = 2'd2; run(FRAME);
        bright = 2'd3;

        // Per-digit blanking
        do_load(16'h5678, 4'b1111, 4'b0110, 1'b0);
        run(2 * FRAME);

        // Randomized loads and brightness changes
        repeat (600) begin
            if ($urandom_range(0, 19) == 0) begin
                data  = 16'($urandom);
                dp    = 4'($urandom);
                blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                lz_en = 1'($urandom);
                data  = ($urandom_range(0, 2) == 0) ? (data & 16'h00FF) : data;
                load  = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) bright = 2'($urandom);
            step();
            load = 1'b0;
        end

        // Reset mid-frame with a pending load: it must be discarded
        bright = 2'd3;
        align(5);
        do_load(16'hABCD, 4'h0, 4'h0, 1'b0);
        run(3);
        rst_step();
        run(FRAME + 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
